// File: rtl/shared_buffer_pkg.sv
// Shared definitions for the SABER shared shift buffer.
// Opcode encoding, default widths and the op legality check.
package shared_buffer_pkg;

  localparam int BUF_W_DEF = 676;
  localparam int IN_W_DEF  = 64;
  localparam int LEN_W_DEF = 7;
  localparam int WIN_W_DEF = 10;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_DRAIN = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  function automatic logic op_legal(
    input logic [1:0]  op,
    input int unsigned len,
    input int unsigned win,
    input int unsigned in_w,
    input int unsigned buf_w
  );
    return (op != OP_RSVD) && (len >= 1) &&
           (len <= in_w) && (win >= len) &&
           (win <= buf_w);
  endfunction

endpackage

// File: rtl/shared_shift_buffer_p_shifter.sv
// Combinational window shifter: shifts buf_i[W-1:0] right by L and
// inserts data_i[L-1:0] (or zeros) at the window top. Ports: buf_i,
// data_i, len_i (L), win_i (W), zero_i (zero-fill), nxt_o.
module window_shifter
  import shared_buffer_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic [BUF_W-1:0] buf_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WIN_W-1:0] win_i,
  input  logic             zero_i,
  output logic [BUF_W-1:0] nxt_o
);

  logic [BUF_W-1:0] win_mask;
  logic [BUF_W-1:0] low;
  logic [BUF_W-1:0] data_ext;
  logic [IN_W-1:0]  data_m;
  logic [WIN_W-1:0] len_w;
  logic [WIN_W-1:0] up_sh;

  assign win_mask = ~({BUF_W{1'b1}} << win_i);
  assign data_m   = data_i & ~({IN_W{1'b1}} << len_i);
  assign len_w    = {{(WIN_W-LEN_W){1'b0}}, len_i};
  // Only meaningful when W >= L; illegal ops discard the result.
  assign up_sh    = win_i - len_w;
  assign low      = (buf_i & win_mask) >> len_i;

  assign data_ext = zero_i ? '0 :
    ({{(BUF_W-IN_W){1'b0}}, data_m} << up_sh);

  assign nxt_o = (buf_i & ~win_mask) | low | data_ext;

endmodule

// File: rtl/shared_shift_buffer_p.sv
// Multi-client shared shift buffer with fixed-priority arbiter and
// occupancy tracking. Ports: ch_req/op/len/win/data per channel in,
// ch_gnt one-hot grant out, buffer/occ/full/empty/ovf/unf/err out.
module shared_shift_buffer_p
  import shared_buffer_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int NCH   = 4,
  parameter int LEN_W = LEN_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     ch_req,
  input  logic [2*NCH-1:0]   ch_op,
  input  logic [LEN_W*NCH-1:0] ch_len,
  input  logic [WIN_W*NCH-1:0] ch_win,
  input  logic [IN_W*NCH-1:0]  ch_data,
  output logic [NCH-1:0]     ch_gnt,
  output logic [BUF_W-1:0]   buffer,
  output logic [WIN_W-1:0]   occ,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  output logic               unf,
  output logic               err
);

  logic [NCH-1:0]   gnt;
  logic             any_req;
  logic [1:0]       sel_op;
  logic [LEN_W-1:0] sel_len;
  logic [WIN_W-1:0] sel_win;
  logic [IN_W-1:0]  sel_data;
  logic             legal;

  logic [BUF_W-1:0] shift_nxt;
  logic [BUF_W-1:0] clr_mask;
  logic [WIN_W-1:0] len_w;
  logic [WIN_W:0]   sum;
  logic [WIN_W-1:0] diff;

  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [WIN_W-1:0] occ_q, occ_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic err_q, err_d;

  // Isolate lowest set request bit.
  assign gnt     = ch_req & (~ch_req + NCH'(1));
  assign ch_gnt  = gnt;
  assign any_req = |ch_req;

  always_comb begin
    sel_op   = '0;
    sel_len  = '0;
    sel_win  = '0;
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_op   = ch_op[2*i +: 2];
        sel_len  = ch_len[LEN_W*i +: LEN_W];
        sel_win  = ch_win[WIN_W*i +: WIN_W];
        sel_data = ch_data[IN_W*i +: IN_W];
      end
    end
  end

  assign legal = op_legal(sel_op, 32'(sel_len),
                          32'(sel_win), IN_W, BUF_W);

  window_shifter #(
    .BUF_W(BUF_W),
    .IN_W (IN_W),
    .LEN_W(LEN_W),
    .WIN_W(WIN_W)
  ) u_shift (
    .buf_i (buffer_q),
    .data_i(sel_data),
    .len_i (sel_len),
    .win_i (sel_win),
    .zero_i(sel_op == OP_DRAIN),
    .nxt_o (shift_nxt)
  );

  assign clr_mask = ~({BUF_W{1'b1}} << sel_win);
  assign len_w    = {{(WIN_W-LEN_W){1'b0}}, sel_len};
  assign sum      = {1'b0, occ_q} + {1'b0, len_w};
  assign diff     = occ_q - len_w;

  always_comb begin
    buffer_d = buffer_q;
    occ_d    = occ_q;
    full_d   = full_q;
    empty_d  = empty_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    err_d    = 1'b0;
    if (any_req) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        unique case (sel_op)
          OP_LOAD: begin
            buffer_d = shift_nxt;
            if (sum > {1'b0, sel_win}) begin
              occ_d = sel_win;
              ovf_d = 1'b1;
            end else begin
              occ_d = sum[WIN_W-1:0];
            end
          end
          OP_DRAIN: begin
            buffer_d = shift_nxt;
            if (len_w > occ_q) begin
              occ_d = '0;
              unf_d = 1'b1;
            end else if (diff > sel_win) begin
              // Window shrank mid-stream: clamp.
              occ_d = sel_win;
            end else begin
              occ_d = diff;
            end
          end
          OP_CLEAR: begin
            buffer_d = buffer_q & ~clr_mask;
            occ_d    = '0;
          end
          default: ;
        endcase
        full_d  = (occ_d == sel_win);
        empty_d = (occ_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      buffer_q <= buffer_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
    end
  end

  assign buffer = buffer_q;
  assign occ    = occ_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_shared_shift_buffer_p.sv
// Directed self-checking bench for shared_shift_buffer_p.
// Hand-computed expectations for arbitration, shifting and flags.
module tb_shared_shift_buffer_p;
  import shared_buffer_pkg::*;

  localparam int BUF_W = 676;
  localparam int IN_W  = 64;
  localparam int NCH   = 4;
  localparam int LEN_W = 7;
  localparam int WIN_W = 10;

  typedef logic [BUF_W-1:0] bv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0]       ch_req;
  logic [2*NCH-1:0]     ch_op;
  logic [LEN_W*NCH-1:0] ch_len;
  logic [WIN_W*NCH-1:0] ch_win;
  logic [IN_W*NCH-1:0]  ch_data;
  logic [NCH-1:0]       ch_gnt;
  logic [BUF_W-1:0]     buffer;
  logic [WIN_W-1:0]     occ;
  logic full, empty, ovf, unf, err;

  int errors = 0;
  int checks = 0;
  bv_t exp_b;
  logic [IN_W-1:0] d;

  always #5 clk = ~clk;

  shared_shift_buffer_p #(
    .BUF_W(BUF_W), .IN_W(IN_W), .NCH(NCH),
    .LEN_W(LEN_W), .WIN_W(WIN_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ch_req (ch_req),
    .ch_op  (ch_op),
    .ch_len (ch_len),
    .ch_win (ch_win),
    .ch_data(ch_data),
    .ch_gnt (ch_gnt),
    .buffer (buffer),
    .occ    (occ),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf),
    .err    (err)
  );

  task automatic check(input string tag, input bv_t got,
                       input bv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic flags(input string tag, input int o,
                       input logic f, input logic e,
                       input logic ov, input logic un,
                       input logic er);
    check({tag, ".occ"},   bv_t'(occ),   bv_t'(o));
    check({tag, ".full"},  bv_t'(full),  bv_t'(f));
    check({tag, ".empty"}, bv_t'(empty), bv_t'(e));
    check({tag, ".ovf"},   bv_t'(ovf),   bv_t'(ov));
    check({tag, ".unf"},   bv_t'(unf),   bv_t'(un));
    check({tag, ".err"},   bv_t'(err),   bv_t'(er));
  endtask

  task automatic idle();
    ch_req  = '0;
    ch_op   = '0;
    ch_len  = '0;
    ch_win  = '0;
    ch_data = '0;
  endtask

  task automatic drive(input int c, input logic [1:0] op,
                       input int len, input int win,
                       input logic [IN_W-1:0] dat);
    ch_req[c]                = 1'b1;
    ch_op[2*c +: 2]          = op;
    ch_len[LEN_W*c +: LEN_W] = LEN_W'(len);
    ch_win[WIN_W*c +: WIN_W] = WIN_W'(win);
    ch_data[IN_W*c +: IN_W]  = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int il_op[4]  = '{0, 0, 3, 1};
  int il_len[4] = '{0, 8, 8, 20};
  int il_win[4] = '{100, 700, 100, 10};

  initial begin
    idle();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++)
      drive(c, OP_LOAD, 8, 8, 64'hFF);
    tick();
    tick();
    check("rst.buf", buffer, '0);
    flags("rst", 0, 0, 1, 0, 0, 0);
    idle();
    rst_n = 1'b1;
    #1;
    check("gnt.none", bv_t'(ch_gnt), '0);
    tick();
    check("rst.rel", buffer, '0);
    check("rst.rel.occ", bv_t'(occ), '0);

    drive(1, OP_LOAD, 40, 320, 64'hA5);
    drive(3, OP_LOAD, 8, 8, 64'hFF);
    #1;
    check("gnt.pri", bv_t'(ch_gnt), bv_t'(4'b0010));
    tick();
    idle();
    exp_b = bv_t'(40'hA5) << 280;
    check("pri.buf", buffer, exp_b);
    flags("pri", 40, 0, 0, 0, 0, 0);

    do_reset();
    exp_b = '0;
    for (int k = 1; k <= 5; k++) begin
      d = 64'h1111_1111_1111_1111 * k;
      drive(0, OP_LOAD, 64, 320, d);
      tick();
      idle();
      check("fill.occ", bv_t'(occ), bv_t'(64 * k));
      exp_b = exp_b | (bv_t'(d) << (64 * (k - 1)));
    end
    check("fill.buf", buffer, exp_b);
    flags("fill", 320, 1, 0, 0, 0, 0);
    d = 64'hDEAD_BEEF_0BAD_F00D;
    drive(2, OP_LOAD, 64, 320, d);
    tick();
    idle();
    exp_b = (exp_b >> 64) | (bv_t'(d) << 256);
    check("ovf.buf", buffer, exp_b);
    flags("ovf", 320, 1, 0, 1, 0, 0);
    tick();
    flags("ovf.idle", 320, 1, 0, 0, 0, 0);

    do_reset();
    drive(2, OP_LOAD, 16, 64, 64'hFFFF_FFFF_FFFF_BEEF);
    tick();
    idle();
    check("dr.ld", buffer, bv_t'(16'hBEEF) << 48);
    drive(2, OP_DRAIN, 40, 64, '0);
    tick();
    idle();
    check("dr.buf", buffer, bv_t'(24'hBEEF00));
    flags("unf", 0, 0, 1, 0, 1, 0);
    tick();
    check("unf.idle", bv_t'(unf), '0);

    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(0, OP_LOAD, 64, 676, '1);
      tick();
      idle();
    end
    check("ones.buf", buffer, '1);
    flags("ones", 676, 1, 0, 1, 0, 0);
    drive(1, OP_LOAD, 64, 112, 64'h0123_4567_89AB_CDEF);
    tick();
    idle();
    exp_b = '1;
    exp_b[111:48] = 64'h0123_4567_89AB_CDEF;
    check("iso.buf", buffer, exp_b);
    flags("iso", 112, 1, 0, 1, 0, 0);
    drive(3, OP_DRAIN, 13, 676, '0);
    tick();
    idle();
    exp_b = exp_b >> 13;
    check("d13.buf", buffer, exp_b);
    flags("d13", 99, 0, 0, 0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      drive(2, 2'(il_op[k]), il_len[k], il_win[k], 64'h77);
      #1;
      check("ill.gnt", bv_t'(ch_gnt), bv_t'(4'b0100));
      tick();
      idle();
      check("ill.buf", buffer, exp_b);
      flags("ill", 99, 0, 0, 0, 0, 1);
    end
    tick();
    check("ill.idle", bv_t'(err), '0);

    drive(0, OP_LOAD, 64, 64, 64'hCAFE_F00D_1234_5678);
    tick();
    idle();
    exp_b[63:0] = 64'hCAFE_F00D_1234_5678;
    check("lw.buf", buffer, exp_b);
    flags("lw", 64, 1, 0, 1, 0, 0);

    drive(1, OP_CLEAR, 1, 32, '0);
    tick();
    idle();
    exp_b[31:0] = '0;
    check("clr.buf", buffer, exp_b);
    flags("clr", 0, 0, 1, 0, 0, 0);

    drive(0, OP_LOAD, 8, 8, 64'h33);
    rst_n = 1'b0;
    tick();
    check("mid.buf", buffer, '0);
    rst_n = 1'b1;
    idle();
    drive(0, OP_LOAD, 8, 8, 64'h5A);
    tick();
    idle();
    check("post.buf", buffer, bv_t'(8'h5A));
    flags("post", 8, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_shift_buffer_p.md
# shared_shift_buffer_p

Parametrised multi-client shift buffer for the SABER datapath. It serves as the single wide working register shared by the rounding, bit-unpacking, message-add and polynomial-multiply stages. Any of NCH clients loads or drains a variable-width chunk into a run-time-selected low window of the buffer. A fixed-priority arbiter picks one client per cycle, and occupancy tracking gives full/empty/overflow/underflow status that the fixed-width predecessor lacked.

## Interface
- BUF_W, 676, total buffer width in bits
- IN_W, 64, maximum chunk width per operation
- NCH, 4, number of client channels
- LEN_W, 7, width of chunk-length field (holds 0..IN_W)
- WIN_W, 10, width of window-length and occupancy fields (holds 0..BUF_W)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- ch_req  in  NCH  per-channel request
- ch_op  in  2*NCH  per-channel opcode: 0 LOAD, 1 DRAIN, 2 CLEAR, 3 reserved
- ch_len  in  LEN_W*NCH  chunk length L in bits
- ch_win  in  WIN_W*NCH  window length W in bits (active region is buffer[W-1:0])
- ch_data  in  IN_W*NCH  load data, LSB-aligned, bits above L ignored
- ch_gnt  out  NCH  one-hot grant, combinational from ch_req
- buffer  out  BUF_W  buffer contents, registered
- occ  out  WIN_W  occupied bit count, registered
- full  out  1  occ == W of last accepted op, registered
- empty  out  1  occ == 0, registered
- ovf  out  1  one-cycle pulse: LOAD exceeded window
- unf  out  1  one-cycle pulse: DRAIN exceeded occupancy
- err  out  1  one-cycle pulse: illegal op accepted

## Operation
- Arbitration: lowest-index requesting channel wins; ch_gnt is all-zero when there is no request. Losers keep ch_req high and are not queued.
- Legality: L in 1..IN_W, W in L..BUF_W, op != 3. An illegal granted op leaves buffer/occ/full/empty unchanged, pulses err and is still granted.
- LOAD: buffer[W-1:0] <= {data[L-1:0], buffer[W-1:L]}; buffer[BUF_W-1:W] unchanged; occ <= min(occ+L, W); ovf pulses if occ+L > W.
- DRAIN: buffer[W-1:0] <= {L'b0, buffer[W-1:L]}; upper bits unchanged; occ <= max(occ-L, 0); unf pulses if L > occ.
- CLEAR: buffer[W-1:0] <= 0, occ <= 0; L ignored.
- full is recomputed against the W of the accepted op. With no op, full, empty and occ hold; ovf, unf and err drop to 0.
- Occupancy is a single counter. A client changing W mid-stream is responsible for consistency: on the next accepted op the counter is clamped to the new W.

## Timing
- Reset (rst_n low at a clock edge): buffer=0, occ=0, empty=1, full=0, ovf=unf=err=0. Reset overrides any request in the same cycle.
- ch_gnt is valid in the request cycle. The effect of the granted op is visible on buffer/occ/flags one cycle after the edge at which it was granted. Throughput is one op per cycle.
- Back-to-back ops from the same or different channels chain: each op uses the register values produced by the previous edge.
- Reset asserted mid-stream discards the in-flight op. The first op after rst_n rises sees an empty buffer.
- Boundary values: W == BUF_W is legal; L == W is legal (a full-window replace or drain); occ == W followed by a LOAD keeps occ == W and pulses ovf.

## Structure
- Package shared_buffer_pkg: op encoding (OP_LOAD, OP_DRAIN, OP_CLEAR), default BUF_W/IN_W/LEN_W/WIN_W, and a legality-check function.
- Sub-module window_shifter: combinational. Inputs are buffer, data, L, W and a zero-fill select; output is the next buffer value. It is instanced once after the grant mux.
- The top level holds the arbiter, the operand mux, the legality check, the occ/flag registers and the buffer register.

## Test plan
- Reset: hold rst_n=0 with ch_req=4'b1111 -> buffer=0, occ=0, empty=1, no grant effect after release.
- Priority: ch_req=4'b1010, ch1 LOAD L=40 W=320 data=40'hA5 -> ch_gnt=4'b0010; next cycle buffer[319:280]=40'hA5, occ=40.
- Fill/overflow: 5 LOADs L=64 W=320 -> occ=320, full=1; a sixth LOAD -> occ=320, ovf pulses once, buffer[319:256]=new data.
- Drain/underflow: occ=16 W=64, DRAIN L=40 -> occ=0, empty=1, unf pulses, buffer[63:24]=0.
- Window isolation: W=112 LOAD L=64 with buffer[675:112] preloaded to 1s -> upper bits unchanged; a 13-bit DRAIN at W=676 shifts the whole buffer right 13.
- Illegal: L=0 or W=700 or op=3 -> err pulses, buffer/occ unchanged, grant still asserted.
